// File: rtl/decode_queue.sv
// decode_queue: RV32I/M/Zicsr decoder feeding a DEPTH-entry FIFO of decoded
// records, placed between fetch and register-read/execute.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every buffered entry and the same-cycle accept/pop
//   in_valid/in_ready fetch handshake; in_ready depends on count only
//   in_pc, in_instr   offered PC and raw instruction word
//   out_valid/out_ready  consumer handshake on the head entry
//   out_pc, out_raw   head PC and raw word
//   out_class         0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,
//                     7 OP_IMM,8 OP,9 MULDIV,10 FENCE,11 SYSTEM,12 CSR,15 ILLEGAL
//   out_funct         {alt, funct3}; alt = instr[30] for OP and SRAI
//   out_imm           decoded immediate (zimm for CSR*I)
//   out_rd/rs1/rs2    register addresses, 0 when unused
//   out_illegal       head class is ILLEGAL
//   count             occupancy
module decode_queue #(
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b1,
  parameter int PC_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_raw,
  output logic [3:0]               out_class,
  output logic [3:0]               out_funct,
  output logic [31:0]              out_imm,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [3:0] CL_LUI     = 4'd0;
  localparam logic [3:0] CL_AUIPC   = 4'd1;
  localparam logic [3:0] CL_JAL     = 4'd2;
  localparam logic [3:0] CL_JALR    = 4'd3;
  localparam logic [3:0] CL_BRANCH  = 4'd4;
  localparam logic [3:0] CL_LOAD    = 4'd5;
  localparam logic [3:0] CL_STORE   = 4'd6;
  localparam logic [3:0] CL_OP_IMM  = 4'd7;
  localparam logic [3:0] CL_OP      = 4'd8;
  localparam logic [3:0] CL_MULDIV  = 4'd9;
  localparam logic [3:0] CL_FENCE   = 4'd10;
  localparam logic [3:0] CL_SYSTEM  = 4'd11;
  localparam logic [3:0] CL_CSR     = 4'd12;
  localparam logic [3:0] CL_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     raw;
    logic [3:0]      cls;
    logic [3:0]      funct;
    logic [31:0]     imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          dec_rec;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          accept, pop;

  // ---------------- decode ----------------
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        alt;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    dec_rec     = '0;
    alt         = 1'b0;
    dec_rec.cls = CL_ILLEGAL;
    case (opc)
      7'b0110111: begin
        dec_rec.cls = CL_LUI;   dec_rec.rd = in_instr[11:7]; dec_rec.imm = imm_u;
      end
      7'b0010111: begin
        dec_rec.cls = CL_AUIPC; dec_rec.rd = in_instr[11:7]; dec_rec.imm = imm_u;
      end
      7'b1101111: begin
        dec_rec.cls = CL_JAL;   dec_rec.rd = in_instr[11:7]; dec_rec.imm = imm_j;
      end
      7'b1100111: if (f3 == 3'b000) begin
        dec_rec.cls = CL_JALR;  dec_rec.rd = in_instr[11:7];
        dec_rec.rs1 = in_instr[19:15]; dec_rec.imm = imm_i;
      end
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
        dec_rec.cls = CL_BRANCH; dec_rec.rs1 = in_instr[19:15];
        dec_rec.rs2 = in_instr[24:20]; dec_rec.imm = imm_b;
      end
      7'b0000011: if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
        dec_rec.cls = CL_LOAD;  dec_rec.rd = in_instr[11:7];
        dec_rec.rs1 = in_instr[19:15]; dec_rec.imm = imm_i;
      end
      7'b0100011: if (f3 <= 3'b010) begin
        dec_rec.cls = CL_STORE; dec_rec.rs1 = in_instr[19:15];
        dec_rec.rs2 = in_instr[24:20]; dec_rec.imm = imm_s;
      end
      7'b0010011: begin
        // Shift-immediates reuse the top of the I-immediate as funct7.
        if ((f3 == 3'b001 && f7 == 7'b0000000) ||
            (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
            (f3 != 3'b001 && f3 != 3'b101)) begin
          dec_rec.cls = CL_OP_IMM; dec_rec.rd = in_instr[11:7];
          dec_rec.rs1 = in_instr[19:15]; dec_rec.imm = imm_i;
          alt = (f3 == 3'b101) && in_instr[30];
        end
      end
      7'b0110011: begin
        if (f7 == 7'b0000000 ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec_rec.cls = CL_OP; alt = in_instr[30];
        end else if (f7 == 7'b0000001 && ENABLE_M) begin
          dec_rec.cls = CL_MULDIV;
        end
        if (dec_rec.cls != CL_ILLEGAL) begin
          dec_rec.rd  = in_instr[11:7];
          dec_rec.rs1 = in_instr[19:15];
          dec_rec.rs2 = in_instr[24:20];
        end
      end
      7'b0001111: if (f3 == 3'b000 || f3 == 3'b001) dec_rec.cls = CL_FENCE;
      7'b1110011: begin
        if (f3 == 3'b000) begin
          if (in_instr == 32'h0000_0073 || in_instr == 32'h0010_0073 ||
              in_instr == 32'h3020_0073)
            dec_rec.cls = CL_SYSTEM;
        end else if (f3 != 3'b100) begin
          dec_rec.cls = CL_CSR;
          dec_rec.rd  = in_instr[11:7];
          // f3[2] selects the immediate forms: rs1 field carries zimm.
          if (f3[2]) dec_rec.imm = {27'b0, in_instr[19:15]};
          else       dec_rec.rs1 = in_instr[19:15];
        end
      end
      default: ;
    endcase
    dec_rec.funct = {alt, f3};
    dec_rec.pc    = in_pc;
    dec_rec.raw   = in_instr;
  end

  // ---------------- FIFO ----------------
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= dec_rec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !accept) count <= count - (AW+1)'(1);
    end
  end

  assign out_pc      = mem[rd_ptr].pc;
  assign out_raw     = mem[rd_ptr].raw;
  assign out_class   = mem[rd_ptr].cls;
  assign out_funct   = mem[rd_ptr].funct;
  assign out_imm     = mem[rd_ptr].imm;
  assign out_rd      = mem[rd_ptr].rd;
  assign out_rs1     = mem[rd_ptr].rs1;
  assign out_rs2     = mem[rd_ptr].rs2;
  assign out_illegal = (mem[rd_ptr].cls == CL_ILLEGAL);

endmodule
